// File: rtl/spi_pkg.sv
// Shared SPI link constants: default word size, synchronizer depth, FSM state encoding.
package spi_pkg;

    // Default word length, shared with the SPI bus master.
    localparam int unsigned SPI_BUS_WIDTH = 8;

    // Number of flops in each pin synchronizer.
    localparam int unsigned SYNC_STAGES = 2;

    // Responder FSM states.
    typedef logic [0:0] spi_state_t;
    localparam spi_state_t IDLE   = 1'b0;
    localparam spi_state_t ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// N-stage pin synchronizer with registered rise/fall detection.
// q is delayed one flop past the synchronizer so that it lines up with the
// sample that produced rise/fall, keeping data and clock pins aligned.
// STAGES must be at least 2.
module spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // Synchronizer chain, edge-detect history flop and registered edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
            fall <= ~sync[STAGES-1] & prev;
        end
    end

    assign q = prev;

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI responder oversampled by the system clock.
// Returns d_out on SO and delivers each received word on d_in with rx_valid.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = spi_pkg::SPI_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CS,
    input  logic                 SCLK,
    input  logic                 SI,
    output logic                 SO,
    input  logic [BUS_WIDTH-1:0] d_out,
    output logic [BUS_WIDTH-1:0] d_in,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = $clog2(BUS_WIDTH) + 1;

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, si_q;
    logic cs_q_unused, sclk_q_unused, si_rise_unused, si_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .d(CS),
        .q(cs_q_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(SCLK),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_si (
        .clk(clk), .rst(rst), .d(SI),
        .q(si_q), .rise(si_rise_unused), .fall(si_fall_unused)
    );

    // The MSB is always on SO, so the tx register only holds the bits still to send;
    // the rx register holds the first BUS_WIDTH-1 bits, the last one comes straight from SI.
    spi_state_t           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic [BUS_WIDTH-2:0] rx_shift, rx_n;
    logic [BUS_WIDTH-2:0] tx_shift, tx_n;
    logic [BUS_WIDTH-1:0] rx_word, d_in_n;
    logic                 so_n, rx_valid_n, busy_n, frame_err_n;
    logic                 word_seen, word_seen_n;

    // Next-state logic; CS events take priority over SCLK events.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rx_n        = rx_shift;
        tx_n        = tx_shift;
        so_n        = SO;
        d_in_n      = d_in;
        rx_valid_n  = 1'b0;
        busy_n      = busy;
        frame_err_n = 1'b0;
        word_seen_n = word_seen;
        rx_word     = {rx_shift, si_q};
        cnt_inc     = cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                so_n   = 1'b1;
                busy_n = 1'b0;
                if (cs_fall) begin
                    tx_n        = d_out[BUS_WIDTH-2:0];
                    so_n        = d_out[BUS_WIDTH-1];
                    cnt_n       = '0;
                    busy_n      = 1'b1;
                    word_seen_n = 1'b0;
                    state_n     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // A partial word is dropped; d_in keeps the last full word.
                    state_n     = IDLE;
                    so_n        = 1'b1;
                    busy_n      = 1'b0;
                    cnt_n       = '0;
                    frame_err_n = (cnt != '0);
                end else if (sclk_rise) begin
                    rx_n = rx_word[BUS_WIDTH-2:0];
                    if (cnt_inc == CNT_W'(BUS_WIDTH)) begin
                        d_in_n      = rx_word;
                        rx_valid_n  = 1'b1;
                        cnt_n       = '0;
                        word_seen_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else if (sclk_fall) begin
                    if (cnt != '0) begin
                        so_n = tx_shift[BUS_WIDTH-2];
                        tx_n = tx_shift << 1;
                    end else if (word_seen) begin
                        // Word boundary inside one frame: fetch the next word to return.
                        tx_n = d_out[BUS_WIDTH-2:0];
                        so_n = d_out[BUS_WIDTH-1];
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            SO        <= 1'b1;
            d_in      <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            word_seen <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rx_shift  <= rx_n;
            tx_shift  <= tx_n;
            SO        <= so_n;
            d_in      <= d_in_n;
            rx_valid  <= rx_valid_n;
            busy      <= busy_n;
            frame_err <= frame_err_n;
            word_seen <= word_seen_n;
        end
    end

endmodule
